pipe_ctrl_unit: RTL and testbench

Central run-control and hazard controller for the 5-stage IF/ID/EXE/MEM/WB integer pipeline.
- Sequences the pipeline from idle through run, load-use stall and drain to halt.
- Generates the PC and IF/ID write enables and the ID/EXE bubble.
- Produces the fwda/fwdb operand-forward selects consumed by the ID-stage operand muxes.
- Tracks per-stage valid bits so it can count retired instructions and detect an empty pipeline.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_ctrl_unit_if.sv | 47 ++++
 rtl/pipe_ctrl_unit_fwd_sel.sv | 37 +++
 rtl/pipe_ctrl_unit.sv | 178 +++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline run-control block: FSM states,
// operand-forward selects and the default register-address width.
package pipe_ctrl_pkg;

    localparam int RA_W_DEFAULT = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STALL = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_MDO = 2'd3;

    // The controller is busy whenever it is neither parked nor halted.
    function automatic logic state_is_busy(state_e s);
        return (s != S_IDLE) && (s != S_HALT);
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Hazard/run-control bus between the pipeline datapath (master) and
// pipe_ctrl_unit (slave): ID/EXE/MEM register info in, enables and selects out.
interface pipe_ctrl_unit_if
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W  = RA_W_DEFAULT,
    parameter int CNT_W = 16
) ();

    logic             run_req;
    logic             halt_req;
    logic [RA_W-1:0]  id_rs;
    logic [RA_W-1:0]  id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             ewreg;
    logic             em2reg;
    logic [RA_W-1:0]  ewr;
    logic             mwreg;
    logic             mm2reg;
    logic [RA_W-1:0]  mwr;

    logic             pc_we;
    logic             ifid_we;
    logic             idexe_bubble;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic [2:0]       state;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output run_req, halt_req, id_rs, id_rt, id_use_rs, id_use_rt,
               ewreg, em2reg, ewr, mwreg, mm2reg, mwr,
        input  pc_we, ifid_we, idexe_bubble, fwda, fwdb, state, busy,
               stall_cnt, retire_cnt
    );

    modport slave (
        input  run_req, halt_req, id_rs, id_rt, id_use_rs, id_use_rt,
               ewreg, em2reg, ewr, mwreg, mm2reg, mwr,
        output pc_we, ifid_we, idexe_bubble, fwda, fwdb, state, busy,
               stall_cnt, retire_cnt
    );

endinterface

// File: rtl/pipe_ctrl_unit_fwd_sel.sv
// pipe_fwd_sel: combinational operand-forward select for one ID-stage
// source register; EXE beats MEM, r0 never forwards, an EXE load is skipped.
module pipe_fwd_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W = RA_W_DEFAULT
) (
    input  logic            use_op,
    input  logic [RA_W-1:0] src,
    input  logic            ewreg,
    input  logic            em2reg,
    input  logic [RA_W-1:0] ewr,
    input  logic            mwreg,
    input  logic            mm2reg,
    input  logic [RA_W-1:0] mwr,
    output logic [1:0]      sel
);

    logic exe_hit;
    logic mem_hit;

    // A load in EXE has no data yet; that case is the load-use stall instead.
    assign exe_hit = ewreg && !em2reg && (ewr != '0) && (ewr == src);
    assign mem_hit = mwreg && (mwr != '0) && (mwr == src);

    always_comb begin
        sel = FWD_RF;
        if (use_op) begin
            if (exe_hit) begin
                sel = FWD_EXE;
            end else if (mem_hit) begin
                sel = mm2reg ? FWD_MDO : FWD_MEM;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Run-control and hazard controller for the 5-stage IF/ID/EXE/MEM/WB pipeline.
// Build option PIPE_CTRL_PERF_EN adds the stall and retire counters (else tied to 0).
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int RA_W  = RA_W_DEFAULT
) (
    input  logic             clk,
    input  logic             start,
    pipe_ctrl_unit_if.slave  bus
);

    state_e state_q, state_d;
    logic   halt_pend_q, halt_pend_d;
    logic   v_id_q, v_id_d;
    logic   v_exe_q, v_exe_d;
    logic   v_mem_q, v_mem_d;
    logic   v_wb_q, v_wb_d;

    logic   load_use;
    logic   rs_dep;
    logic   rt_dep;
    logic   pc_we;
    logic   ifid_we;
    logic   bubble;
    logic   enter_stall;

    assign rs_dep   = bus.id_use_rs && (bus.ewr == bus.id_rs);
    assign rt_dep   = bus.id_use_rt && (bus.ewr == bus.id_rt);
    assign load_use = bus.ewreg && bus.em2reg && (bus.ewr != '0) && (rs_dep || rt_dep);

    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_pend_q;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        bubble      = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (bus.run_req) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.halt_req) begin
                    halt_pend_d = 1'b1;
                end
                // The stall wins over a simultaneous halt; halt_pend carries it.
                if (load_use) begin
                    state_d = S_STALL;
                end else begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                    bubble  = 1'b0;
                    if (bus.halt_req || halt_pend_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_STALL: begin
                pc_we   = 1'b1;
                ifid_we = 1'b1;
                bubble  = 1'b0;
                if (bus.halt_req) begin
                    halt_pend_d = 1'b1;
                end
                state_d = (halt_pend_q || bus.halt_req) ? S_DRAIN : S_RUN;
            end
            S_DRAIN: begin
                if (!(v_exe_q || v_mem_q || v_wb_q)) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ID holds its instruction while IF/ID is frozen; a bubble empties EXE.
    always_comb begin
        v_id_d  = ifid_we ? pc_we : v_id_q;
        v_exe_d = v_id_q && !bubble;
        v_mem_d = v_exe_q;
        v_wb_d  = v_mem_q;
    end

    assign enter_stall = (state_q != S_STALL) && (state_d == S_STALL);

    always_ff @(posedge clk) begin
        if (start) begin
            state_q     <= S_IDLE;
            halt_pend_q <= 1'b0;
            v_id_q      <= 1'b0;
            v_exe_q     <= 1'b0;
            v_mem_q     <= 1'b0;
            v_wb_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
            v_id_q      <= v_id_d;
            v_exe_q     <= v_exe_d;
            v_mem_q     <= v_mem_d;
            v_wb_q      <= v_wb_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    // Both counters wrap naturally at 2^CNT_W.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (enter_stall) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (v_wb_q) begin
            retire_cnt_d = retire_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            stall_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.retire_cnt = retire_cnt_q;
`else
    logic perf_unused;

    assign perf_unused    = enter_stall;
    assign bus.stall_cnt  = {CNT_W{1'b0}};
    assign bus.retire_cnt = {CNT_W{1'b0}};
`endif

    pipe_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
        .use_op (bus.id_use_rs),
        .src    (bus.id_rs),
        .ewreg  (bus.ewreg),
        .em2reg (bus.em2reg),
        .ewr    (bus.ewr),
        .mwreg  (bus.mwreg),
        .mm2reg (bus.mm2reg),
        .mwr    (bus.mwr),
        .sel    (bus.fwda)
    );

    pipe_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
        .use_op (bus.id_use_rt),
        .src    (bus.id_rt),
        .ewreg  (bus.ewreg),
        .em2reg (bus.em2reg),
        .ewr    (bus.ewr),
        .mwreg  (bus.mwreg),
        .mm2reg (bus.mm2reg),
        .mwr    (bus.mwr),
        .sel    (bus.fwdb)
    );

    assign bus.pc_we        = pc_we;
    assign bus.ifid_we      = ifid_we;
    assign bus.idexe_bubble = bubble;
    assign bus.state        = state_q;
    assign bus.busy         = state_is_busy(state_q);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit (CNT_W=4 so the retire counter wraps);
// counter expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl_unit;
    import pipe_ctrl_pkg::*;

    localparam int CW = 4;
    localparam int AW = 5;
    localparam logic [18:0] M_CTL = 19'h7FF00;
    localparam logic [18:0] M_STL = 19'h7FFF0;
    localparam logic [18:0] M_ALL = 19'h7FFFF;

    logic clk = 1'b0;
    logic start = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.RA_W(AW), .CNT_W(CW)) bif ();
    pipe_ctrl_unit #(.CNT_W(CW), .RA_W(AW)) dut (.clk(clk), .start(start), .bus(bif));

    typedef struct {int st, rr, hr, rs, rt, urs, urt, ew, em, ewr, mw, mm, mwr;} stim_t;
    typedef struct {string tag; logic [18:0] want; logic [18:0] mask;} exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [18:0] obs;

    assign obs = {bif.state, bif.pc_we, bif.ifid_we, bif.idexe_bubble, bif.fwda, bif.fwdb,
                  bif.busy, bif.stall_cnt, bif.retire_cnt};

    function automatic logic [3:0] cnt(int n);
`ifdef PIPE_CTRL_PERF_EN
        return 4'(n);
`else
        return 4'(n) & 4'd0;
`endif
    endfunction

    function automatic logic [18:0] mk(int s, int p, int i, int b, int fa, int fb, int sc, int rc);
        logic bz;
        bz = (s != 0) && (s != 4);
        return {3'(s), 1'(p), 1'(i), 1'(b), 2'(fa), 2'(fb), bz, cnt(sc), cnt(rc)};
    endfunction

    function automatic logic lu_of(stim_t s);
        return (s.ew != 0) && (s.em != 0) && (s.ewr != 0) &&
               (((s.urs != 0) && (s.ewr == s.rs)) || ((s.urt != 0) && (s.ewr == s.rt)));
    endfunction

    task automatic drive(stim_t s);
        @(posedge clk);
        #1;
        start         = 1'(s.st);
        bif.run_req   = 1'(s.rr);
        bif.halt_req  = 1'(s.hr);
        bif.id_rs     = 5'(s.rs);
        bif.id_rt     = 5'(s.rt);
        bif.id_use_rs = 1'(s.urs);
        bif.id_use_rt = 1'(s.urt);
        bif.ewreg     = 1'(s.ew);
        bif.em2reg    = 1'(s.em);
        bif.ewr       = 5'(s.ewr);
        bif.mwreg     = 1'(s.mw);
        bif.mm2reg    = 1'(s.mm);
        bif.mwr       = 5'(s.mwr);
    endtask

    task automatic test_reset();
        stim_t s;
        exp_t e;
        s = '{default: 0};
        s.st = 1;
        drive(s);
        drive(s);
        exp_q.push_back('{"reset", mk(0, 0, 0, 1, 0, 0, 0, 0), M_ALL});
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ((obs & e.mask) !== (e.want & e.mask)) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", e.tag, obs & e.mask, e.want & e.mask);
        end
    endtask

    // IDLE -> RUN; first retire appears four edges after the first fetch.
    task automatic test_run();
        stim_t s;
        exp_t e;
        s = '{default: 0};
        s.rr = 1;
        for (int j = -1; j <= 5; j++) begin
            drive(s);
            if (j < 0) exp_q.push_back('{"run_idle", mk(0, 0, 0, 1, 0, 0, 0, 0), M_ALL});
            else exp_q.push_back('{$sformatf("run_c%0d", j), mk(1, 1, 1, 0, 0, 0, 0, (j > 4) ? j - 4 : 0), M_ALL});
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ((obs & e.mask) !== (e.want & e.mask)) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.tag, obs & e.mask, e.want & e.mask);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t st [3] = '{'{0,0,0, 2,0, 1,0, 1,1,2, 0,0,0},
                          '{0,0,0, 2,0, 1,0, 0,0,0, 1,1,2},
                          '{0,0,0, 0,0, 0,0, 0,0,0, 0,0,0}};
        logic [18:0] want [3];
        exp_t e;
        want[0] = mk(1, 0, 0, 1, 0, 0, 0, 0);
        want[1] = mk(2, 1, 1, 0, 3, 0, 1, 0);
        want[2] = mk(1, 1, 1, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            drive(st[k]);
            exp_q.push_back('{$sformatf("load_use_%0d", k), want[k], (k == 0) ? M_CTL : M_STL});
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ((obs & e.mask) !== (e.want & e.mask)) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.tag, obs & e.mask, e.want & e.mask);
            end
            if (bif.state == 3'd2) begin
                n_cmp++;
                if (lu_of(st[k])) begin
                    n_bad++;
                    $display("FAIL stall_reuse: load_use %0d seen in STALL, required 0", lu_of(st[k]));
                end
            end
        end
    endtask

    task automatic test_fwd();
        stim_t st [8] = '{'{0,0,0, 0,3, 0,1, 1,0,3, 1,0,3},
                          '{0,0,0, 0,3, 0,1, 0,0,3, 1,0,3},
                          '{0,0,0, 0,0, 0,1, 1,0,0, 1,0,0},
                          '{0,0,0, 0,3, 0,1, 0,0,0, 1,1,3},
                          '{0,0,0, 7,9, 1,1, 1,0,7, 1,0,9},
                          '{0,0,0, 7,9, 0,0, 1,0,7, 1,0,9},
                          '{0,0,0, 6,0, 1,0, 1,1,5, 1,0,6},
                          '{0,0,0, 4,4, 1,1, 1,0,4, 1,1,4}};
        int fa [8] = '{0, 0, 0, 0, 1, 0, 2, 1};
        int fb [8] = '{1, 2, 0, 3, 2, 0, 0, 1};
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            drive(st[k]);
            exp_q.push_back('{$sformatf("fwd_%0d", k), mk(1, 1, 1, 0, fa[k], fb[k], 0, 0), M_CTL});
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ((obs & e.mask) !== (e.want & e.mask)) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.tag, obs & e.mask, e.want & e.mask);
            end
        end
    endtask

    // Halt alongside a load-use: one stall, four drain cycles, then HALT holds.
    task automatic test_halt_drain();
        stim_t s;
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            s = '{default: 0};
            if (k == 0) s = '{0,0,1, 2,0, 1,0, 1,1,2, 0,0,0};
            if (k == 1) s = '{0,0,0, 2,0, 1,0, 0,0,0, 1,1,2};
            if (k >= 6) s.rr = 1;
            drive(s);
            if (k == 0) exp_q.push_back('{"halt_lu", mk(1, 0, 0, 1, 0, 0, 0, 0), M_CTL});
            else if (k == 1) exp_q.push_back('{"halt_stall", mk(2, 1, 1, 0, 3, 0, 2, 0), M_STL});
            else if (k <= 5) exp_q.push_back('{$sformatf("drain_%0d", k), mk(3, 0, 0, 1, 0, 0, 2, 0), M_STL});
            else exp_q.push_back('{$sformatf("halt_%0d", k), mk(4, 0, 0, 1, 0, 0, 2, 0), M_STL});
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ((obs & e.mask) !== (e.want & e.mask)) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.tag, obs & e.mask, e.want & e.mask);
            end
            if (bif.state == 3'd2) begin
                n_cmp++;
                if (lu_of(s)) begin
                    n_bad++;
                    $display("FAIL stall_reuse: load_use %0d seen in STALL, required 0", lu_of(s));
                end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        stim_t s;
        exp_t e;
        for (int k = 0; k < 13; k++) begin
            s = '{default: 0};
            if (k == 0 || k == 8) s.st = 1;
            if (k == 1) s.rr = 1;
            if (k == 7) s.hr = 1;
            drive(s);
            if (k == 0) continue;
            if (k == 1) exp_q.push_back('{"rst_idle", mk(0, 0, 0, 1, 0, 0, 0, 0), M_ALL});
            else if (k <= 7) exp_q.push_back('{$sformatf("rst_run_%0d", k), mk(1, 1, 1, 0, 0, 0, 0, (k > 6) ? k - 6 : 0), M_ALL});
            else if (k == 8) exp_q.push_back('{"rst_drain", mk(3, 0, 0, 1, 0, 0, 0, 2), M_ALL});
            else exp_q.push_back('{$sformatf("rst_after_%0d", k), mk(0, 0, 0, 1, 0, 0, 0, 0), M_ALL});
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ((obs & e.mask) !== (e.want & e.mask)) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.tag, obs & e.mask, e.want & e.mask);
            end
        end
    endtask

    // 20 retirements into a 4-bit counter leave 4.
    task automatic test_retire_wrap();
        stim_t s;
        exp_t e;
        for (int k = -2; k <= 24; k++) begin
            s = '{default: 0};
            if (k == -2) s.st = 1;
            else s.rr = 1;
            drive(s);
            if (k == -2) continue;
            if (k == -1) exp_q.push_back('{"wrap_idle", mk(0, 0, 0, 1, 0, 0, 0, 0), M_ALL});
            else exp_q.push_back('{$sformatf("wrap_c%0d", k), mk(1, 1, 1, 0, 0, 0, 0, (k > 4) ? k - 4 : 0), M_ALL});
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ((obs & e.mask) !== (e.want & e.mask)) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.tag, obs & e.mask, e.want & e.mask);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run();
        test_load_use();
        test_fwd();
        test_halt_drain();
        test_reset_mid_drain();
        test_retire_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
